// File: rtl/branch_resolver.sv
// Branch resolution unit: detects mispredicts in EX, drives a one-cycle front-end flush,
// and queues predictor update packets. Optional mispredict counter under BR_RESOLVER_STATS_EN.
module branch_resolver (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [1:0]  ex_type,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic [32:0] pred_pack,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic        upd_valid,
   input  logic        upd_ready,
   output logic [66:0] upd_info,
   output logic        queue_full
`ifdef BR_RESOLVER_STATS_EN
   ,
   output logic [31:0] mispredict_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLUSH  = 2'd1,
      S_SQUASH = 2'd2
   } state_e;

   state_e      state_q;
   logic        flush_q;
   logic [31:0] redirect_q;

   logic [66:0] mem_q [0:3];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;

   logic        pred_dir_s;
   logic [31:0] pred_tar_s;
   logic        accept_s;
   logic        mispredict_s;
   logic [31:0] redir_tgt_s;
   logic        empty_s;
   logic        full_s;
   logic        pop_s;
   logic        push_s;
   logic [66:0] entry_s;

   assign pred_dir_s = pred_pack[32];
   assign pred_tar_s = pred_pack[31:0];

   // Resolutions are only taken while the FSM is idle and EX is not stalled.
   assign accept_s     = ex_valid && !stall && (state_q == S_IDLE);
   assign mispredict_s = (ex_taken != pred_dir_s) ||
                         (ex_taken && pred_dir_s && (ex_target != pred_tar_s));
   assign redir_tgt_s  = ex_taken ? ex_target : (ex_pc + 32'd8);

   assign empty_s = (count_q == 3'd0);
   assign full_s  = (count_q == 3'd4);
   assign pop_s   = !empty_s && upd_ready;
   assign push_s  = accept_s && (!full_s || pop_s);
   assign entry_s = {ex_pc, ex_taken, ex_target, ex_type};

   // Control FSM with registered flush pulse and redirect address.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         flush_q    <= 1'b0;
         redirect_q <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s && mispredict_s) begin
                  state_q    <= S_FLUSH;
                  flush_q    <= 1'b1;
                  redirect_q <= redir_tgt_s;
               end else begin
                  state_q    <= S_IDLE;
                  flush_q    <= 1'b0;
                  redirect_q <= 32'd0;
               end
            end
            S_FLUSH: begin
               state_q    <= S_SQUASH;
               flush_q    <= 1'b0;
               redirect_q <= 32'd0;
            end
            S_SQUASH: begin
               state_q    <= S_IDLE;
               flush_q    <= 1'b0;
               redirect_q <= 32'd0;
            end
            default: begin
               state_q    <= S_IDLE;
               flush_q    <= 1'b0;
               redirect_q <= 32'd0;
            end
         endcase
      end
   end

   assign flush       = flush_q;
   assign redirect_pc = redirect_q;

   // Next-state for the update queue pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + 2'd1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   // Queue pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage; contents are masked by occupancy so need no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= entry_s;
      end
   end

   assign upd_valid  = !empty_s;
   assign upd_info   = empty_s ? 67'd0 : mem_q[rd_ptr_q];
   assign queue_full = full_s;

`ifdef BR_RESOLVER_STATS_EN
   logic [31:0] mispredict_cnt_q;

   // Accepted-mispredict counter, wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mispredict_cnt_q <= 32'd0;
      end else if (accept_s && mispredict_s) begin
         mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end else begin
         mispredict_cnt_q <= mispredict_cnt_q;
      end
   end

   assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios followed by random traffic,
// all checked against a queue-based behavioural model.
module tb_branch_resolver;

   logic        clk;
   logic        resetn;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [1:0]  ex_type;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic [32:0] pred_pack;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        upd_valid;
   logic        upd_ready;
   logic [66:0] upd_info;
   logic        queue_full;
`ifdef BR_RESOLVER_STATS_EN
   logic [31:0] mispredict_cnt;
`endif

   branch_resolver dut (
      .clk         (clk),
      .resetn      (resetn),
      .stall       (stall),
      .ex_valid    (ex_valid),
      .ex_pc       (ex_pc),
      .ex_type     (ex_type),
      .ex_taken    (ex_taken),
      .ex_target   (ex_target),
      .pred_pack   (pred_pack),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .upd_info    (upd_info),
      .queue_full  (queue_full)
`ifdef BR_RESOLVER_STATS_EN
      ,
      .mispredict_cnt (mispredict_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests;
   int fails;

   // Behavioural model: packet queue, cycles remaining in the post-mispredict blackout,
   // latched restart address and mispredict count.
   logic [66:0] mq [$];
   int          m_busy;
   logic [31:0] m_redir;
   logic [31:0] m_cnt;

   task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic st, input logic [31:0] pc, input logic [1:0] ty,
                      input logic tk, input logic [31:0] tg, input logic pd, input logic [31:0] pt);
      ex_valid  = v;
      stall     = st;
      ex_pc     = pc;
      ex_type   = ty;
      ex_taken  = tk;
      ex_target = tg;
      pred_pack = {pd, pt};
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   // One clock: check DUT against model mid-cycle, advance the model, cross the edge.
   task automatic step();
      logic acc;
      logic mis;
      logic pop;
      logic was_full;
      logic [66:0] exp_head;
      @(negedge clk);
      exp_head = (mq.size() != 0) ? mq[0] : 67'd0;
      chk("flush", {66'd0, flush}, {66'd0, (m_busy == 2)});
      chk("redirect_pc", {35'd0, redirect_pc}, {35'd0, (m_busy == 2) ? m_redir : 32'd0});
      chk("upd_valid", {66'd0, upd_valid}, {66'd0, (mq.size() != 0)});
      chk("upd_info", upd_info, exp_head);
      chk("queue_full", {66'd0, queue_full}, {66'd0, (mq.size() == 4)});
`ifdef BR_RESOLVER_STATS_EN
      chk("mispredict_cnt", {35'd0, mispredict_cnt}, {35'd0, m_cnt});
`endif
      acc      = ex_valid && !stall && (m_busy == 0);
      mis      = (ex_taken != pred_pack[32]) ||
                 (ex_taken && pred_pack[32] && (ex_target != pred_pack[31:0]));
      pop      = (mq.size() != 0) && upd_ready;
      was_full = (mq.size() == 4);
      if (!resetn) begin
         mq.delete();
         m_busy = 0;
         m_cnt  = 32'd0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc && (!was_full || pop)) mq.push_back({ex_pc, ex_taken, ex_target, ex_type});
         if (m_busy > 0) begin
            m_busy = m_busy - 1;
         end else if (acc && mis) begin
            m_busy  = 2;
            m_redir = ex_taken ? ex_target : ex_pc + 32'd8;
            m_cnt   = m_cnt + 32'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      resetn    = 1'b0;
      upd_ready = 1'b0;
      idle();
      @(posedge clk);
      #1;
      mq.delete();
      m_busy  = 0;
      m_redir = 32'd0;
      m_cnt   = 32'd0;
      step();
      chk("rst_flush", {66'd0, flush}, 67'd0);
      chk("rst_upd_info", upd_info, 67'd0);
      chk("rst_queue_full", {66'd0, queue_full}, 67'd0);
      resetn = 1'b1;

      // Correct taken prediction: no flush, packet at head next cycle.
      drv(1'b1, 1'b0, 32'h1000, 2'd1, 1'b1, 32'h2000, 1'b1, 32'h2000);
      step();
      idle();
      chk("ok_no_flush", {66'd0, flush}, 67'd0);
      chk("ok_upd_valid", {66'd0, upd_valid}, 67'd1);
      chk("ok_upd_info", upd_info, {32'h1000, 1'b1, 32'h2000, 2'd1});
      upd_ready = 1'b1;
      step();
      upd_ready = 1'b0;

      // Not taken but predicted taken: restart past the delay slot; EX ignored for two cycles.
      drv(1'b1, 1'b0, 32'h1000, 2'd0, 1'b0, 32'h5555, 1'b1, 32'h2000);
      step();
      chk("nt_flush", {66'd0, flush}, 67'd1);
      chk("nt_redirect", {35'd0, redirect_pc}, {35'd0, 32'h1008});
      drv(1'b1, 1'b0, 32'h2000, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      step();
      chk("squash_flush", {66'd0, flush}, 67'd0);
      step();
      chk("ignored_in_blackout", {66'd0, upd_valid}, {66'd0, 1'b1});
      step();
      chk("accepted_after", {66'd0, queue_full}, 67'd0);
      upd_ready = 1'b1;
      idle();
      repeat (3) step();
      chk("drained", {66'd0, upd_valid}, 67'd0);

      // Taken to wrong target, then PC wrap on not-taken.
      drv(1'b1, 1'b0, 32'h1100, 2'd3, 1'b1, 32'h3000, 1'b1, 32'h2000);
      step();
      idle();
      chk("tgt_redirect", {35'd0, redirect_pc}, {35'd0, 32'h3000});
      repeat (2) step();
      drv(1'b1, 1'b0, 32'hFFFF_FFFC, 2'd0, 1'b0, 32'h0, 1'b1, 32'h8);
      step();
      idle();
      chk("wrap_redirect", {35'd0, redirect_pc}, {35'd0, 32'h0000_0004});
      repeat (4) step();

      // Five correct resolutions with predictor back-pressure: fifth is dropped.
      upd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, 1'b0, 32'h4000 + 32'(i * 4), 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
         step();
         if (i == 3) chk("full_after_4", {66'd0, queue_full}, 67'd1);
      end
      idle();
      upd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", {35'd0, upd_info[66:35]}, {35'd0, 32'h4000 + 32'(i * 4)});
         step();
      end
      chk("drain_empty", {66'd0, upd_valid}, 67'd0);

      // Full queue: simultaneous push and pop keeps it full; stalled EX is ignored.
      upd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 1'b0, 32'h5000 + 32'(i * 4), 2'd2, 1'b1, 32'h6000, 1'b1, 32'h6000);
         step();
      end
      upd_ready = 1'b1;
      drv(1'b1, 1'b0, 32'h5010, 2'd2, 1'b1, 32'h6000, 1'b1, 32'h6000);
      step();
      chk("pushpop_full", {66'd0, queue_full}, 67'd1);
      chk("pushpop_head", {35'd0, upd_info[66:35]}, {35'd0, 32'h5004});
      upd_ready = 1'b0;
      drv(1'b1, 1'b1, 32'h7000, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0);
      step();
      chk("stall_no_flush", {66'd0, flush}, 67'd0);
      idle();
      upd_ready = 1'b1;
      repeat (5) step();

      // Reset while flushing discards everything.
      upd_ready = 1'b0;
      drv(1'b1, 1'b0, 32'h8000, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0);
      step();
      chk("pre_rst_flush", {66'd0, flush}, 67'd1);
      idle();
      resetn = 1'b0;
      step();
      chk("rst_in_flush", {66'd0, flush}, 67'd0);
      chk("rst_queue_empty", {66'd0, upd_valid}, 67'd0);
      resetn = 1'b1;
      step();

      // Three mispredicts for the optional counter.
      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 1'b0, 32'h9000, 2'd0, 1'b1, 32'h9100, 1'b0, 32'h0);
         step();
         idle();
         repeat (2) step();
      end
`ifdef BR_RESOLVER_STATS_EN
      chk("cnt_three", {35'd0, mispredict_cnt}, {35'd0, 32'd3});
`endif
      upd_ready = 1'b1;
      repeat (4) step();

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         logic        tk;
         logic [31:0] tg;
         logic [31:0] pc;
         int          mode;
         tk   = 1'($urandom_range(0, 1));
         tg   = $urandom;
         pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
         mode = $urandom_range(0, 3);
         case (mode)
            0:       drv(1'b1, 1'b0, pc, 2'($urandom), tk, tg, tk, tg);
            1:       drv(1'b1, 1'b0, pc, 2'($urandom), tk, tg, !tk, tg);
            2:       drv(1'b1, 1'b0, pc, 2'($urandom), 1'b1, tg, 1'b1, tg ^ 32'h10);
            default: drv(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 4) == 0), pc,
                         2'($urandom), tk, tg, 1'($urandom_range(0, 1)), $urandom);
         endcase
         upd_ready = ($urandom_range(0, 2) == 0);
         resetn    = ($urandom_range(0, 49) != 0);
         step();
      end
      resetn = 1'b1;
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
